voting_booth_arbiter: RTL and testbench
=======================================

// Module: voting_booth_arbiter
// PURPOSE
//  Shares one voting_machine among N_BOOTHS booth terminals.
//  Grants booths round-robin, replays each booth's login and ballot into the machine
//  with fixed-cycle sequencing, then returns a result code to the granted booth.
//  Sits between the booth front-ends and the voting_machine instance; it owns all
//  machine input pins.
// PARAMETERS
//  N_BOOTHS  4    number of requesting booths (2..8)
//  TIMEOUT   255  max cycles to wait for vote_done after submit before declaring fault
// PORTS
//  clk            in   1           system clock, all logic on posedge
//  rst            in   1           synchronous, active-high reset
//  polls_open     in   1           new grants allowed only while high
//  b_req          in   N_BOOTHS    per-booth request, level; booth holds fields stable while high
//  b_voter_id     in   2*N_BOOTHS  booth i in [2i+1:2i]
//  b_password     in   8*N_BOOTHS  booth i in [8i+7:8i]
//  b_vote         in   2*N_BOOTHS  booth i in [2i+1:2i]; valid 0..2
//  b_done         out  N_BOOTHS    one-hot, 1-cycle pulse to the finished booth
//  status         out  3           result, valid while b_done != 0
//  busy           out  1           transaction in progress
//  fault          out  1           sticky machine timeout
//  m_start        out  1           to machine start
//  m_submit       out  1           to machine submit
//  m_voter_id     out  2           to machine voter_id
//  m_password     out  8           to machine password
//  m_vote         out  2           to machine vote
//  m_vote_done    in   1           from machine vote_done
//  m_invalid      in   1           from machine invalid_login
//  m_already      in   1           from machine already_voted
// BEHAVIOUR
//  Reset: all outputs 0, state ARB, rr pointer 0, timer 0, fault cleared.
//  Status codes: 001 accepted, 010 invalid login, 011 already voted, 100 timeout,
//  101 bad ballot (vote==3).
//  FSM (one state per cycle unless noted):
//   ARB      Grant when polls_open & |b_req & !fault: the first requester at/after
//            the rr pointer. Latch index and fields into m_* regs.
//            If latched vote==3 -> FINISH with 101; no machine activity.
//            Otherwise -> START.
//   START    m_start=1 (machine IDLE->AUTH).
//   AUTH     m_start=1 (machine evaluates password).
//   CHECK    m_start=1. m_invalid -> FINISH(010); m_already -> FINISH(011);
//            else -> SUBMIT.
//   SUBMIT   m_start=1, m_submit=1 for exactly 1 cycle.
//   WAITD    m_start=1. m_vote_done -> FINISH(001). Timer counts from 0; at
//            TIMEOUT -> FINISH(100) and fault<=1.
//   FINISH   m_start=0, b_done[idx]=1, status driven. rr pointer <= idx+1 mod N.
//            -> RECOVER, or -> FAULT if fault.
//   RECOVER  m_start=0, 1 cycle; the machine returns to IDLE and clears its flags.
//            -> ARB.
//   FAULT    Absorbing until rst; b_done never pulses again; m_* held 0.
//  Latency, grant to b_done:
//   accepted: 6 cycles min (ARB, START, AUTH, CHECK, SUBMIT, WAITD -> FINISH)
//   login reject: 4 cycles
//   bad ballot: 1 cycle
//   Next grant no earlier than 2 cycles after b_done.
//  busy=1 in every state except ARB and FAULT.
//  m_voter_id, m_password, m_vote are held from ARB latch through FINISH.
//  Booth changes to fields mid-transaction are ignored.
//  The booth must drop b_req in the cycle after b_done. A req still high at the next
//  ARB is a new request; the machine then returns already voted.
//  polls_open falling mid-transaction: current transaction completes; no new grant.
//  Simultaneous requests: only the rr winner is granted. Losers keep b_req high and
//  see no b_done.
//  Ungranted b_req toggling has no effect. rst mid-transaction aborts immediately:
//  all outputs 0, no b_done.
// TESTING
//  T1 booth0 id0 pw A5 vote1 -> m_submit at grant+4, b_done[0] at grant+6 or later,
//     status 001.
//  T2 booth2 id1 pw 00 -> b_done[2] at grant+4, status 010, m_submit never high.
//  T3 booth1 id0 pw A5 again after T1 -> status 011; machine counts unchanged.
//  T4 all 4 booths req together, valid distinct ids -> b_done order 0,1,2,3, then
//     pointer wraps to 0.
//  T5 booth3 vote=3 -> b_done[3] 1 cycle after grant, status 101, m_start never high.
//  T6 tie m_vote_done=0 -> status 100 at TIMEOUT, fault=1, further reqs ignored
//     until rst.

Source files
------------

// File: rtl/voting_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : voting_booth_arbiter
// Description : Shares a single voting_machine among N_BOOTHS booth terminals.
//               Booths are granted round-robin. The granted booth's login and
//               ballot are replayed into the machine with fixed-cycle
//               sequencing, and a result code is returned to that booth.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               polls_open           - gates new grants
//               b_req/b_voter_id/b_password/b_vote - packed per-booth requests
//               b_done, status       - one-hot completion pulse + result code
//               busy, fault          - transaction in flight / sticky timeout
//               m_*                  - voting_machine pin interface
// Revision    : 1.0 - initial release
// ============================================================================
module voting_booth_arbiter #(
    parameter int N_BOOTHS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    polls_open,
    input  logic [N_BOOTHS-1:0]     b_req,
    input  logic [2*N_BOOTHS-1:0]   b_voter_id,
    input  logic [8*N_BOOTHS-1:0]   b_password,
    input  logic [2*N_BOOTHS-1:0]   b_vote,
    output logic [N_BOOTHS-1:0]     b_done,
    output logic [2:0]              status,
    output logic                    busy,
    output logic                    fault,
    output logic                    m_start,
    output logic                    m_submit,
    output logic [1:0]              m_voter_id,
    output logic [7:0]              m_password,
    output logic [1:0]              m_vote,
    input  logic                    m_vote_done,
    input  logic                    m_invalid,
    input  logic                    m_already
);

    localparam int IDX_W = $clog2(N_BOOTHS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] c_S_ARB     = 4'd0;
    localparam logic [3:0] c_S_START   = 4'd1;
    localparam logic [3:0] c_S_AUTH    = 4'd2;
    localparam logic [3:0] c_S_CHECK   = 4'd3;
    localparam logic [3:0] c_S_SUBMIT  = 4'd4;
    localparam logic [3:0] c_S_WAITD   = 4'd5;
    localparam logic [3:0] c_S_FINISH  = 4'd6;
    localparam logic [3:0] c_S_RECOVER = 4'd7;
    localparam logic [3:0] c_S_FAULT   = 4'd8;

    localparam logic [2:0] c_ST_NONE    = 3'b000;
    localparam logic [2:0] c_ST_ACCEPT  = 3'b001;
    localparam logic [2:0] c_ST_INVALID = 3'b010;
    localparam logic [2:0] c_ST_ALREADY = 3'b011;
    localparam logic [2:0] c_ST_TIMEOUT = 3'b100;
    localparam logic [2:0] c_ST_BADVOTE = 3'b101;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_status;
    logic             r_fault;
    logic [1:0]       r_id;
    logic [7:0]       r_pw;
    logic [1:0]       r_vote;

    logic [2:0]       w_fin_code;
    logic             w_timeout;
    logic             w_gnt_valid;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_slot;
    logic             w_grant;

    logic [1:0] w_id_arr   [N_BOOTHS];
    logic [7:0] w_pw_arr   [N_BOOTHS];
    logic [1:0] w_vote_arr [N_BOOTHS];

    for (genvar g = 0; g < N_BOOTHS; g++) begin : g_unpack
        assign w_id_arr[g]   = b_voter_id[2*g +: 2];
        assign w_pw_arr[g]   = b_password[8*g +: 8];
        assign w_vote_arr[g] = b_vote[2*g +: 2];
    end

    // Round-robin pick: scan from the farthest slot back to the pointer so the
    // last hit (nearest at/after the pointer) wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_slot      = '0;
        for (int k = N_BOOTHS - 1; k >= 0; k--) begin
            w_slot = IDX_W'((int'(r_ptr) + k) % N_BOOTHS);
            if (b_req[w_slot]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_slot;
            end
        end
    end

    assign w_grant = polls_open & w_gnt_valid & ~r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fin_code  = c_ST_NONE;
        w_timeout   = 1'b0;
        m_start     = 1'b0;
        m_submit    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_S_ARB: begin
                busy = 1'b0;
                if (w_grant) begin
                    // Illegal ballot is answered locally; the machine never sees it.
                    if (w_vote_arr[w_gnt_idx] == 2'd3) begin
                        w_state_nxt = c_S_FINISH;
                        w_fin_code  = c_ST_BADVOTE;
                    end else begin
                        w_state_nxt = c_S_START;
                    end
                end
            end
            c_S_START: begin
                m_start     = 1'b1;
                w_state_nxt = c_S_AUTH;
            end
            c_S_AUTH: begin
                m_start     = 1'b1;
                w_state_nxt = c_S_CHECK;
            end
            c_S_CHECK: begin
                m_start = 1'b1;
                if (m_invalid) begin
                    w_state_nxt = c_S_FINISH;
                    w_fin_code  = c_ST_INVALID;
                end else if (m_already) begin
                    w_state_nxt = c_S_FINISH;
                    w_fin_code  = c_ST_ALREADY;
                end else begin
                    w_state_nxt = c_S_SUBMIT;
                end
            end
            c_S_SUBMIT: begin
                m_start     = 1'b1;
                m_submit    = 1'b1;
                w_state_nxt = c_S_WAITD;
            end
            c_S_WAITD: begin
                m_start = 1'b1;
                if (m_vote_done) begin
                    w_state_nxt = c_S_FINISH;
                    w_fin_code  = c_ST_ACCEPT;
                end else if (r_timer == TMR_W'(TIMEOUT)) begin
                    w_state_nxt = c_S_FINISH;
                    w_fin_code  = c_ST_TIMEOUT;
                    w_timeout   = 1'b1;
                end
            end
            c_S_FINISH: begin
                w_state_nxt = r_fault ? c_S_FAULT : c_S_RECOVER;
            end
            c_S_RECOVER: begin
                w_state_nxt = c_S_ARB;
            end
            c_S_FAULT: begin
                busy = 1'b0;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_S_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
            r_status <= c_ST_NONE;
            r_fault  <= 1'b0;
            r_id     <= '0;
            r_pw     <= '0;
            r_vote   <= '0;
        end else begin
            // Fields are captured once at grant; later booth edits are ignored.
            if (r_state == c_S_ARB && w_grant) begin
                r_idx  <= w_gnt_idx;
                r_id   <= w_id_arr[w_gnt_idx];
                r_pw   <= w_pw_arr[w_gnt_idx];
                r_vote <= w_vote_arr[w_gnt_idx];
            end
            if (r_state == c_S_SUBMIT) begin
                r_timer <= '0;
            end else if (r_state == c_S_WAITD) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_state_nxt == c_S_FINISH) begin
                r_status <= w_fin_code;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
            if (r_state == c_S_FINISH) begin
                r_ptr <= (r_idx == IDX_W'(N_BOOTHS - 1)) ? '0 : r_idx + 1'b1;
            end
            // Machine pins go quiet for good once the arbiter is faulted.
            if (w_state_nxt == c_S_FAULT) begin
                r_id   <= '0;
                r_pw   <= '0;
                r_vote <= '0;
            end
        end
    end

    always_comb begin
        b_done = '0;
        status = c_ST_NONE;
        if (r_state == c_S_FINISH) begin
            b_done[r_idx] = 1'b1;
            status        = r_status;
        end
    end

    assign fault      = r_fault;
    assign m_voter_id = r_id;
    assign m_password = r_pw;
    assign m_vote     = r_vote;

endmodule
`default_nettype wire

// File: tb/tb_voting_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_voting_booth_arbiter
// Description : Directed bench for voting_booth_arbiter with a small
//               behavioural voting_machine answering on the m_* pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voting_booth_arbiter;

    localparam int N   = 4;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic           polls_open;
    logic [N-1:0]   b_req;
    logic [2*N-1:0] b_voter_id;
    logic [8*N-1:0] b_password;
    logic [2*N-1:0] b_vote;
    logic [N-1:0]   b_done;
    logic [2:0]     status;
    logic           busy;
    logic           fault;
    logic           m_start;
    logic           m_submit;
    logic [1:0]     m_voter_id;
    logic [7:0]     m_password;
    logic [1:0]     m_vote;
    logic           m_vote_done;
    logic           m_invalid;
    logic           m_already;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voting_booth_arbiter #(.N_BOOTHS(N), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .polls_open (polls_open),
        .b_req      (b_req),
        .b_voter_id (b_voter_id),
        .b_password (b_password),
        .b_vote     (b_vote),
        .b_done     (b_done),
        .status     (status),
        .busy       (busy),
        .fault      (fault),
        .m_start    (m_start),
        .m_submit   (m_submit),
        .m_voter_id (m_voter_id),
        .m_password (m_password),
        .m_vote     (m_vote),
        .m_vote_done(m_vote_done),
        .m_invalid  (m_invalid),
        .m_already  (m_already)
    );

    // Behavioural machine: login is checked after two start cycles, a
    // submit records the vote and raises vote_done one cycle later.
    logic [7:0] pw_tab [4];
    int         mc_cnt;
    logic       mc_done;
    logic [3:0] voted;
    int         total;
    logic       tie_done;

    always @(posedge clk) begin
        if (rst) begin
            mc_cnt  <= 0;
            mc_done <= 1'b0;
            voted   <= '0;
            total   <= 0;
        end else if (!m_start) begin
            mc_cnt  <= 0;
            mc_done <= 1'b0;
        end else begin
            if (mc_cnt < 3) mc_cnt <= mc_cnt + 1;
            if (m_submit) begin
                voted[m_voter_id] <= 1'b1;
                total             <= total + 1;
                if (!tie_done) mc_done <= 1'b1;
            end
        end
    end

    assign m_vote_done = mc_done;
    assign m_invalid   = m_start && (mc_cnt >= 2) && (m_password != pw_tab[m_voter_id]);
    assign m_already   = m_start && (mc_cnt >= 2) && (m_password == pw_tab[m_voter_id])
                         && voted[m_voter_id];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_booth(input int b, input logic [1:0] id, input logic [7:0] pw,
                             input logic [1:0] vote);
        b_voter_id[2*b +: 2] = id;
        b_password[8*b +: 8] = pw;
        b_vote[2*b +: 2]     = vote;
    endtask

    // Single-booth transaction starting from ARB; latency counted from the grant cycle.
    task automatic run_booth(input int b, input logic [1:0] id, input logic [7:0] pw,
                             input logic [1:0] vote, output int lat, output int sub_at,
                             output logic start_seen, output logic [3:0] done,
                             output logic [2:0] st, output logic [7:0] pw_seen,
                             output logic [1:0] vote_seen);
        set_booth(b, id, pw, vote);
        b_req[b]   = 1'b1;
        lat        = -1;
        sub_at     = 0;
        start_seen = 1'b0;
        done       = '0;
        st         = '0;
        pw_seen    = '0;
        vote_seen  = '0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (m_start) start_seen = 1'b1;
            if (m_submit) begin
                sub_at    = k;
                pw_seen   = m_password;
                vote_seen = m_vote;
            end
            if (b_done != '0) begin
                lat  = k;
                done = b_done;
                st   = status;
                break;
            end
        end
        b_req[b] = 1'b0;
    endtask

    int         got_k    [4];
    logic [3:0] got_done [4];
    logic [2:0] got_st   [4];
    int         n_got;

    // Gather up to n_exp completions, dropping each finished booth's request.
    task automatic collect(input int n_exp);
        n_got = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (b_done != '0 && n_got < 4) begin
                got_k[n_got]    = k;
                got_done[n_got] = b_done;
                got_st[n_got]   = status;
                b_req           = b_req & ~b_done;
                n_got++;
                if (n_got == n_exp) break;
            end
        end
        check("collect_count", 32'(n_got), 32'(n_exp));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    int         lat, sub_at;
    logic       start_seen;
    logic [3:0] done;
    logic [2:0] st;
    logic [7:0] pw_seen;
    logic [1:0] vote_seen;
    int         done_seen;
    int         start_cnt;

    initial begin
        pw_tab[0] = 8'hA5;
        pw_tab[1] = 8'h3C;
        pw_tab[2] = 8'h5A;
        pw_tab[3] = 8'hC3;
        rst        = 1'b1;
        polls_open = 1'b0;
        b_req      = '0;
        b_voter_id = '0;
        b_password = '0;
        b_vote     = '0;
        tie_done   = 1'b0;
        idle(3);

        // Reset state
        check("rst_b_done", 32'(b_done), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_m_start", 32'(m_start), 32'h0);
        check("rst_m_pw", 32'(m_password), 32'h0);
        rst        = 1'b0;
        polls_open = 1'b1;
        idle(2);

        // T1: accepted vote
        run_booth(0, 2'd0, 8'hA5, 2'd1, lat, sub_at, start_seen, done, st, pw_seen, vote_seen);
        check("t1_submit_at", 32'(sub_at), 32'd4);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_done", 32'(done), 32'h1);
        check("t1_status", 32'(st), 32'h1);
        check("t1_m_pw", 32'(pw_seen), 32'hA5);
        check("t1_m_vote", 32'(vote_seen), 32'h1);
        check("t1_total", 32'(total), 32'd1);
        idle(2);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // T2: invalid login
        run_booth(2, 2'd1, 8'h00, 2'd1, lat, sub_at, start_seen, done, st, pw_seen, vote_seen);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_done", 32'(done), 32'h4);
        check("t2_status", 32'(st), 32'h2);
        check("t2_no_submit", 32'(sub_at), 32'd0);
        idle(2);

        // T3: same voter again from another booth
        run_booth(1, 2'd0, 8'hA5, 2'd2, lat, sub_at, start_seen, done, st, pw_seen, vote_seen);
        check("t3_latency", 32'(lat), 32'd4);
        check("t3_done", 32'(done), 32'h2);
        check("t3_status", 32'(st), 32'h3);
        check("t3_total", 32'(total), 32'd1);
        idle(2);

        // Polls closed: no grant
        polls_open = 1'b0;
        set_booth(0, 2'd2, 8'h5A, 2'd0);
        b_req      = 4'b0001;
        done_seen  = 0;
        start_cnt  = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (b_done != '0) done_seen++;
            if (busy) start_cnt++;
        end
        check("closed_done", 32'(done_seen), 32'd0);
        check("closed_busy", 32'(start_cnt), 32'd0);
        b_req      = '0;
        polls_open = 1'b1;

        // T4: all booths together from pointer 0
        pulse_reset();
        for (int b = 0; b < 4; b++) set_booth(b, 2'(b), pw_tab[b], 2'(b % 3));
        b_req = 4'hF;
        collect(4);
        check("t4_done0", 32'(got_done[0]), 32'h1);
        check("t4_done1", 32'(got_done[1]), 32'h2);
        check("t4_done2", 32'(got_done[2]), 32'h4);
        check("t4_done3", 32'(got_done[3]), 32'h8);
        check("t4_k0", 32'(got_k[0]), 32'd6);
        check("t4_k1", 32'(got_k[1]), 32'd14);
        check("t4_k2", 32'(got_k[2]), 32'd22);
        check("t4_k3", 32'(got_k[3]), 32'd30);
        check("t4_st0", 32'(got_st[0]), 32'h1);
        check("t4_st3", 32'(got_st[3]), 32'h1);
        check("t4_total", 32'(total), 32'd4);
        idle(2);

        // Pointer wrapped to 0: booth0 beats booth1
        b_req = 4'b0011;
        collect(2);
        check("wrap_first", 32'(got_done[0]), 32'h1);
        check("wrap_first_k", 32'(got_k[0]), 32'd4);
        check("wrap_first_st", 32'(got_st[0]), 32'h3);
        check("wrap_second", 32'(got_done[1]), 32'h2);
        check("wrap_second_k", 32'(got_k[1]), 32'd10);
        idle(2);

        // T5: bad ballot
        run_booth(3, 2'd3, 8'hC3, 2'd3, lat, sub_at, start_seen, done, st, pw_seen, vote_seen);
        check("t5_latency", 32'(lat), 32'd1);
        check("t5_done", 32'(done), 32'h8);
        check("t5_status", 32'(st), 32'h5);
        check("t5_no_start", 32'(start_seen), 32'h0);
        idle(2);

        // T6: machine never answers
        pulse_reset();
        tie_done = 1'b1;
        run_booth(2, 2'd2, 8'h5A, 2'd0, lat, sub_at, start_seen, done, st, pw_seen, vote_seen);
        check("t6_submit_at", 32'(sub_at), 32'd4);
        check("t6_latency", 32'(lat), 32'(TMO + 6));
        check("t6_done", 32'(done), 32'h4);
        check("t6_status", 32'(st), 32'h4);
        check("t6_fault", 32'(fault), 32'h1);
        idle(2);
        check("t6_fault_held", 32'(fault), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_m_pw_zero", 32'(m_password), 32'h0);
        set_booth(0, 2'd0, 8'hA5, 2'd1);
        b_req     = 4'b0001;
        done_seen = 0;
        start_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (b_done != '0) done_seen++;
            if (m_start || busy) start_cnt++;
        end
        check("t6_ignored_done", 32'(done_seen), 32'd0);
        check("t6_ignored_act", 32'(start_cnt), 32'd0);
        b_req    = '0;
        tie_done = 1'b0;
        pulse_reset();
        check("t6_fault_cleared", 32'(fault), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
